// File: rtl/cardinal_nic.sv
// cardinal_nic: CPU-facing network interface with one input and one output
// single-flit buffer, bridging the cpu NIC port to a ring router port.
// Bit order follows the codebase convention: bit 0 is the MSB.
//
// Handshake: the router may push a flit on any edge where net_si=1 and
// net_ri=1; the NIC pushes a flit on any edge where net_so=1, which already
// folds in the router's net_ro and the polarity/VC match, so the router
// consumes the flit at every edge where net_so is high.
module cardinal_nic #(
  parameter int DATA_WIDTH = 64,
  parameter int VC_BIT     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity
);

  localparam logic [1:0] ADDR_IBUF    = 2'b00;
  localparam logic [1:0] ADDR_ISTATUS = 2'b01;
  localparam logic [1:0] ADDR_OBUF    = 2'b10;
  localparam logic [1:0] ADDR_OSTATUS = 2'b11;

  logic [0:DATA_WIDTH-1] ibuf_q, ibuf_d;
  logic                  ibuf_full_q, ibuf_full_d;
  logic [0:DATA_WIDTH-1] obuf_q, obuf_d;
  logic                  obuf_full_q, obuf_full_d;
  logic [0:DATA_WIDTH-1] d_out_q, d_out_d;

  logic                  cpu_rd;
  logic                  cpu_wr;
  logic [0:DATA_WIDTH-1] istatus;
  logic [0:DATA_WIDTH-1] ostatus;

  assign cpu_rd = nicEn & ~nicWrEn;
  assign cpu_wr = nicEn & nicWrEn;

  assign d_out  = d_out_q;
  assign net_ri = ~ibuf_full_q;
  assign net_do = obuf_q;
  // Only inject when the flit's VC matches the VC the ring is currently on.
  assign net_so = obuf_full_q & net_ro & (net_polarity == obuf_q[VC_BIT]);

  // Status words carry the full flag in the last (least significant) bit.
  always_comb begin
    istatus = '0;
    ostatus = '0;
    istatus[DATA_WIDTH-1] = ibuf_full_q;
    ostatus[DATA_WIDTH-1] = obuf_full_q;
  end

  // Next-state for cpu reads/writes and both router channels.
  always_comb begin
    ibuf_d      = ibuf_q;
    ibuf_full_d = ibuf_full_q;
    obuf_d      = obuf_q;
    obuf_full_d = obuf_full_q;
    d_out_d     = d_out_q;

    if (cpu_rd) begin
      case (addr)
        ADDR_IBUF: begin
          d_out_d     = ibuf_q;
          ibuf_full_d = 1'b0;
        end
        ADDR_ISTATUS: d_out_d = istatus;
        ADDR_OBUF:    d_out_d = obuf_q;
        ADDR_OSTATUS: d_out_d = ostatus;
        default:      d_out_d = d_out_q;
      endcase
    end

    // Accept only while empty; a strobe against a full buffer is dropped.
    // A read-clear and an accept cannot coincide: accept needs the flag low.
    if (net_si && net_ri) begin
      ibuf_d      = net_di;
      ibuf_full_d = 1'b1;
    end

    // A write to a full obuf is dropped even if that flit leaves this edge.
    if (cpu_wr && (addr == ADDR_OBUF) && !obuf_full_q) begin
      obuf_d      = d_in;
      obuf_full_d = 1'b1;
    end else if (net_so) begin
      obuf_full_d = 1'b0;
    end
  end

  // State registers; reset overrides any simultaneous transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ibuf_q      <= '0;
      ibuf_full_q <= 1'b0;
      obuf_q      <= '0;
      obuf_full_q <= 1'b0;
      d_out_q     <= '0;
    end else begin
      ibuf_q      <= ibuf_d;
      ibuf_full_q <= ibuf_full_d;
      obuf_q      <= obuf_d;
      obuf_full_q <= obuf_full_d;
      d_out_q     <= d_out_d;
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// tb_cardinal_nic: directed vector table, a bounded injection sequence and
// randomized traffic checked against a queue-based model of the NIC.
module tb_cardinal_nic;

  localparam logic [0:63] Z   = 64'h0;
  localparam logic [0:63] ONE = 64'h1;
  localparam logic [0:63] A   = 64'hA5A5_0000_1234_5678;
  localparam logic [0:63] B   = 64'h0000_0000_DEAD_BEEF;
  localparam logic [0:63] C   = 64'h8000_0000_0000_0001;
  localparam logic [0:63] D   = 64'h0123_4567_89AB_CDEF;
  localparam logic [0:63] F   = 64'hFFFF_FFFF_FFFF_FFFF;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [0:63] d_in, d_out, net_di, net_do;
  logic        nicEn, nicWrEn, net_si, net_ri, net_so, net_ro, net_polarity;

  always #5 clk = ~clk;

  cardinal_nic #(.DATA_WIDTH(64), .VC_BIT(0)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [0:63] act, input logic [0:63] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, en, we;
    logic [1:0]  a;
    logic [0:63] din;
    logic        si;
    logic [0:63] di;
    logic        ro, pol;
    logic        chk_pre, e_ri, e_so;
    logic [0:63] e_do, e_dout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, en, we, input logic [1:0] a,
                              input logic [0:63] din, input logic si,
                              input logic [0:63] di, input logic ro, pol,
                              input logic chk_pre, e_ri, e_so,
                              input logic [0:63] e_do, e_dout);
    vec_t v;
    v.rst = rst; v.en = en; v.we = we; v.a = a; v.din = din; v.si = si;
    v.di = di; v.ro = ro; v.pol = pol; v.chk_pre = chk_pre; v.e_ri = e_ri;
    v.e_so = e_so; v.e_do = e_do; v.e_dout = e_dout;
    return v;
  endfunction

  task automatic drive(input logic rst, en, we, input logic [1:0] a,
                       input logic [0:63] din, input logic si,
                       input logic [0:63] di, input logic ro, pol);
    reset = rst; nicEn = en; nicWrEn = we; addr = a; d_in = din;
    net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
  endtask

  // ---------------- reference model ----------------
  logic [0:63] m_ibuf, m_obuf, m_dout;
  logic [0:63] in_q[$];
  logic [0:63] out_q[$];

  initial begin
    int seen_k;
    drive(0, 0, 0, 2'd0, Z, 0, Z, 0, 0);
    @(posedge clk); #1;

    // rst en we a  din  si di ro pol | chk ri so do  dout
    vecs.push_back(mk(1,0,0,2'd0,Z  ,0,Z,0,0, 0,0,0,Z,Z));   // reset
    vecs.push_back(mk(0,1,0,2'd1,Z  ,0,Z,0,0, 1,1,0,Z,Z));   // istatus empty
    vecs.push_back(mk(0,1,0,2'd3,Z  ,0,Z,0,0, 1,1,0,Z,Z));   // ostatus empty
    vecs.push_back(mk(0,0,0,2'd0,Z  ,1,A,0,0, 1,1,0,Z,Z));   // router sends A
    vecs.push_back(mk(0,1,0,2'd1,Z  ,0,Z,0,0, 1,0,0,Z,ONE)); // istatus full
    vecs.push_back(mk(0,1,0,2'd0,Z  ,0,Z,0,0, 1,0,0,Z,A));   // read ibuf
    vecs.push_back(mk(0,1,0,2'd1,Z  ,0,Z,0,0, 1,1,0,Z,Z));   // flag cleared
    vecs.push_back(mk(0,1,1,2'd2,B  ,0,Z,1,0, 1,1,0,Z,Z));   // write B (VC0)
    vecs.push_back(mk(0,0,0,2'd0,Z  ,0,Z,1,1, 1,1,0,B,Z));   // wrong polarity
    vecs.push_back(mk(0,1,1,2'd2,D  ,0,Z,1,0, 1,1,1,B,Z));   // inject; D dropped
    vecs.push_back(mk(0,1,0,2'd3,Z  ,0,Z,1,1, 1,1,0,B,Z));   // ostatus empty
    vecs.push_back(mk(0,1,1,2'd2,C  ,0,Z,0,0, 1,1,0,B,Z));   // write C (VC1)
    vecs.push_back(mk(0,0,0,2'd0,Z  ,0,Z,0,1, 1,1,0,C,Z));   // router not ready
    vecs.push_back(mk(0,0,0,2'd0,Z  ,0,Z,0,0, 1,1,0,C,Z));
    vecs.push_back(mk(0,0,0,2'd0,Z  ,0,Z,0,1, 1,1,0,C,Z));
    vecs.push_back(mk(0,0,0,2'd0,Z  ,0,Z,0,0, 1,1,0,C,Z));
    vecs.push_back(mk(0,1,0,2'd3,Z  ,0,Z,0,1, 1,1,0,C,ONE)); // ostatus full
    vecs.push_back(mk(0,1,1,2'd2,ONE,0,Z,0,0, 1,1,0,C,ONE)); // dropped write
    vecs.push_back(mk(0,1,0,2'd2,Z  ,0,Z,0,1, 1,1,0,C,C));   // obuf still C
    vecs.push_back(mk(0,0,0,2'd0,Z  ,0,Z,1,0, 1,1,0,C,C));   // ready, pol 0
    vecs.push_back(mk(0,0,0,2'd0,Z  ,0,Z,1,1, 1,1,1,C,C));   // inject at pol 1
    vecs.push_back(mk(0,1,0,2'd3,Z  ,0,Z,1,0, 1,1,0,C,Z));   // ostatus empty
    vecs.push_back(mk(0,0,0,2'd0,Z  ,1,A,0,0, 1,1,0,C,Z));   // fill ibuf
    vecs.push_back(mk(0,1,1,2'd2,B  ,0,Z,0,0, 1,0,0,C,Z));   // fill obuf
    vecs.push_back(mk(0,1,0,2'd1,Z  ,0,Z,0,0, 1,0,0,B,ONE)); // both full
    vecs.push_back(mk(1,1,0,2'd3,Z  ,1,C,1,0, 1,0,1,B,Z));   // reset wins
    vecs.push_back(mk(0,1,0,2'd1,Z  ,0,Z,1,0, 1,1,0,Z,Z));
    vecs.push_back(mk(0,1,0,2'd3,Z  ,0,Z,1,0, 1,1,0,Z,Z));
    vecs.push_back(mk(0,1,0,2'd2,Z  ,0,Z,0,0, 1,1,0,Z,Z));
    vecs.push_back(mk(0,1,0,2'd0,Z  ,0,Z,0,0, 1,1,0,Z,Z));
    vecs.push_back(mk(0,1,1,2'd0,F  ,0,Z,0,0, 1,1,0,Z,Z));   // ignored writes
    vecs.push_back(mk(0,1,1,2'd1,F  ,0,Z,0,0, 1,1,0,Z,Z));
    vecs.push_back(mk(0,1,1,2'd3,F  ,0,Z,1,0, 1,1,0,Z,Z));
    vecs.push_back(mk(0,1,0,2'd0,Z  ,0,Z,0,0, 1,1,0,Z,Z));
    vecs.push_back(mk(0,1,0,2'd1,Z  ,0,Z,0,0, 1,1,0,Z,Z));
    vecs.push_back(mk(0,1,0,2'd2,Z  ,0,Z,0,0, 1,1,0,Z,Z));
    vecs.push_back(mk(0,1,0,2'd3,Z  ,0,Z,0,0, 1,1,0,Z,Z));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].we, vecs[i].a, vecs[i].din,
            vecs[i].si, vecs[i].di, vecs[i].ro, vecs[i].pol);
      #1;
      if (vecs[i].chk_pre) begin
        check($sformatf("vec%0d net_ri", i), {63'b0, net_ri}, {63'b0, vecs[i].e_ri});
        check($sformatf("vec%0d net_so", i), {63'b0, net_so}, {63'b0, vecs[i].e_so});
        check($sformatf("vec%0d net_do", i), net_do, vecs[i].e_do);
      end
      @(posedge clk); #1;
      check($sformatf("vec%0d d_out", i), d_out, vecs[i].e_dout);
    end

    // Bounded wait: a VC1 flit with polarity toggling from 0 leaves one cycle late.
    drive(0, 1, 1, 2'd2, C, 0, Z, 0, 0);
    @(posedge clk); #1;
    seen_k = -1;
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 2'd0, Z, 0, Z, 1, k[0]);
      #1;
      if (net_so) seen_k = k;
      @(posedge clk); #1;
      if (seen_k >= 0) break;
    end
    check("inject_cycle", 64'(seen_k), 64'd1);
    drive(0, 1, 0, 2'd3, Z, 0, Z, 1, 0);
    @(posedge clk); #1;
    check("inject_ostatus", d_out, Z);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      logic rst, en, we, si, ro, pol, e_ri, e_so;
      logic [1:0]  a;
      logic [0:63] din, di;
      rst = (i == 0) || ($urandom_range(0, 63) == 0);
      en  = ($urandom_range(0, 3) != 0);
      we  = $urandom_range(0, 1) == 1;
      a   = 2'($urandom_range(0, 3));
      din = {$urandom, $urandom};
      si  = $urandom_range(0, 1) == 1;
      di  = {$urandom, $urandom};
      ro  = $urandom_range(0, 1) == 1;
      pol = $urandom_range(0, 1) == 1;
      drive(rst, en, we, a, din, si, di, ro, pol);
      #1;
      e_ri = (in_q.size() == 0);
      e_so = (out_q.size() != 0) && ro && (pol == m_obuf[0]);
      if (i != 0) begin
        check($sformatf("rnd%0d net_ri", i), {63'b0, net_ri}, {63'b0, e_ri});
        check($sformatf("rnd%0d net_so", i), {63'b0, net_so}, {63'b0, e_so});
        check($sformatf("rnd%0d net_do", i), net_do, m_obuf);
      end
      if (rst) begin
        m_ibuf = Z; m_obuf = Z; m_dout = Z;
        in_q.delete(); out_q.delete();
      end else begin
        if (en && !we) begin
          case (a)
            2'd0: begin
              m_dout = m_ibuf;
              if (in_q.size() != 0) void'(in_q.pop_front());
            end
            2'd1: m_dout = (in_q.size() != 0) ? ONE : Z;
            2'd2: m_dout = m_obuf;
            default: m_dout = (out_q.size() != 0) ? ONE : Z;
          endcase
        end
        if (si && e_ri) begin
          in_q.push_back(di);
          m_ibuf = di;
        end
        if (en && we && a == 2'd2 && out_q.size() == 0) begin
          out_q.push_back(din);
          m_obuf = din;
        end else if (e_so) begin
          void'(out_q.pop_front());
        end
      end
      @(posedge clk); #1;
      check($sformatf("rnd%0d d_out", i), d_out, m_dout);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cardinal_nic.md
Name: cardinal_nic

Overview:
- Network interface controller between the cpu's NIC port (nicAddr, nicDataIn/Out, nicEn, nicWrEn) and one port of the bidirectional ring router.
- Exposes four memory-mapped 64-bit registers to the cpu: input buffer, input status, output buffer and output status.
- Moves single-flit packets between those registers and the router using a ready/send handshake.
- The output channel is gated by router polarity (even/odd virtual channel).

Parameters:
DATA_WIDTH, 64, packet/register width; bit 0 is MSB (codebase bit order [0:DATA_WIDTH-1]).
VC_BIT, 0, index of the packet bit carrying the virtual-channel id.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
addr  input  2  register select from cpu nicAddr: 00 ibuf, 01 istatus, 10 obuf, 11 ostatus.
d_in  input  64  write data from cpu (cpu nicDataOut).
d_out  output  64  registered read data to cpu (cpu nicDataIn).
nicEn  input  1  access enable.
nicWrEn  input  1  1 = write, 0 = read; meaningful only with nicEn.
net_si  input  1  router→NIC send strobe.
net_ri  output  1  NIC ready to accept a packet from the router.
net_di  input  64  packet from router.
net_so  output  1  NIC→router send strobe.
net_ro  input  1  router ready to accept from NIC.
net_do  output  64  packet to router.
net_polarity  input  1  router polarity (current external VC).

Behaviour:
State:
- ibuf[64] and ibuf_full.
- obuf[64] and obuf_full.
- d_out register.

Reset (clk edge with reset=1):
- ibuf, obuf and d_out = 0.
- ibuf_full and obuf_full = 0.
- Outputs: net_ri=1, net_so=0, net_do=0.
- Reset wins over every simultaneous event. A packet in flight is discarded.

Status register format: bit 63 = full flag, bits 0..62 = 0.

CPU read (nicEn=1, nicWrEn=0), one-cycle latency: d_out is loaded at the edge and valid the following cycle.
- 00: d_out ← ibuf. If ibuf_full, it clears at the same edge. Reading an empty ibuf returns stale data and changes no state.
- 01: d_out ← {63'b0, ibuf_full}.
- 10: d_out ← obuf.
- 11: d_out ← {63'b0, obuf_full}.
- If nicEn=0 or a write is performed, d_out holds its value.

CPU write (nicEn=1, nicWrEn=1):
- addr 10 with obuf_full=0: obuf ← d_in and obuf_full ← 1.
- addr 10 with obuf_full=1: write is dropped silently (software must poll ostatus). This holds even if obuf is being injected in the same cycle.
- Writes to 00, 01 and 11 are ignored.

Input channel:
- net_ri = ~ibuf_full (combinational).
- On an edge with net_si=1 and net_ri=1: ibuf ← net_di, ibuf_full ← 1.
- net_si while net_ri=0 is a router protocol violation. Ignore it; ibuf is unchanged.
- A cpu read of 00 clears ibuf_full at edge N. net_ri rises after edge N, so the next packet is accepted no earlier than edge N+1. The two never collide.

Output channel:
- net_do = obuf (combinational).
- net_so = obuf_full & net_ro & (net_polarity == obuf[VC_BIT]) (combinational).
- On an edge with net_so=1, obuf_full ← 0 and obuf retains its data.
- Minimum write-to-inject latency is 1 cycle. Back-to-back packets need at least 2 cycles: write, then inject/clear, then the next write is accepted.
- net_polarity toggles every cycle in the ring, so an injection may wait one extra cycle for the matching VC.

Test Plan:
- Reset then read 01 and 11 → d_out=0 one cycle after each read; net_ri=1, net_so=0.
- Router sends net_di=64'hA5A5_0000_1234_5678 with net_si=1 → net_ri=0 next cycle. Read 01 → d_out=1. Read 00 → d_out=64'hA5A5_0000_1234_5678. net_ri=1 after that edge. Read 01 → 0.
- Write 10 with 64'h0000_0000_DEAD_BEEF (VC bit 0), net_ro=1, net_polarity alternating → net_so asserts only in a cycle with polarity=0 and net_do equals the written value. ostatus reads 0 afterward.
- Write 10 with 64'h8000_0000_0000_0001 (VC=1) while net_ro=0 for 5 cycles → net_so stays 0 and ostatus=1. A second write of 64'h1 is dropped (readback of 10 is still 64'h8000_0000_0000_0001). Raise net_ro → injected on the first cycle with polarity=1.
- Assert reset while ibuf_full=1 and obuf_full=1 → both flags are 0, d_out=0, net_ri=1 and net_so=0 after the edge.
- Writes to 00, 01 and 11 with 64'hFFFF_FFFF_FFFF_FFFF → no change to any buffer or flag, verified by readback.
